// File: rtl/partial_sum_reducer.sv
// Sequential reducer: captures five W-bit partial sums and adds them one per cycle.
// Optional sticky carry-out flag on out_ovf when PSR_OVF_CHECK_EN is defined.
module partial_sum_reducer #(
  parameter int RADIX = 108
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*RADIX-1:0] in_sum_0,
  input  logic [2*RADIX-1:0] in_sum_1,
  input  logic [2*RADIX-1:0] in_sum_2,
  input  logic [2*RADIX-1:0] in_sum_3,
  input  logic [2*RADIX-1:0] in_sum_4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*RADIX-1:0] out_res
`ifdef PSR_OVF_CHECK_EN
  ,
  output logic               out_ovf
`endif
);

  localparam int W = 2 * RADIX;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [2:0]     idx_q, idx_d;
  logic [W-1:0]   sum_q [5];
  logic [W-1:0]   in_sums [5];
  logic [W-1:0]   sum_sel;
  logic           accept;

  assign in_sums[0] = in_sum_0;
  assign in_sums[1] = in_sum_1;
  assign in_sums[2] = in_sum_2;
  assign in_sums[3] = in_sum_3;
  assign in_sums[4] = in_sum_4;

  // in_ready is forced low while reset is held, not just after it.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_res   = out_valid ? acc_q : '0;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_sum
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_q[gi] <= '0;
        end else if (accept) begin
          sum_q[gi] <= in_sums[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    sum_sel = '0;
    case (idx_q)
      3'd0:    sum_sel = sum_q[0];
      3'd1:    sum_sel = sum_q[1];
      3'd2:    sum_sel = sum_q[2];
      3'd3:    sum_sel = sum_q[3];
      3'd4:    sum_sel = sum_q[4];
      default: sum_sel = '0;
    endcase
  end

`ifdef PSR_OVF_CHECK_EN
  logic [W:0] acc_sum;
  logic       ovf_q, ovf_d;
  assign acc_sum = {1'b0, acc_q} + {1'b0, sum_sel};
  assign out_ovf = ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && accept) begin
      ovf_d = 1'b0;
    end else if (state_q == ACCUM) begin
      ovf_d = ovf_q | acc_sum[W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`else
  logic [W-1:0] acc_sum;
  assign acc_sum = acc_q + sum_sel;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACCUM;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      ACCUM: begin
        acc_d = acc_sum[W-1:0];
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd4) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_partial_sum_reducer.sv
// Directed-table plus corner-sequence bench for partial_sum_reducer.
// Honours PSR_OVF_CHECK_EN when the overflow flag is built in.
module tb_partial_sum_reducer;

  localparam int RADIX = 108;
  localparam int W     = 2 * RADIX;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sum_0, in_sum_1, in_sum_2, in_sum_3, in_sum_4;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
`ifdef PSR_OVF_CHECK_EN
  logic         out_ovf;
`endif

  int checks   = 0;
  int failures = 0;

  partial_sum_reducer #(.RADIX(RADIX)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum_0  (in_sum_0),
    .in_sum_1  (in_sum_1),
    .in_sum_2  (in_sum_2),
    .in_sum_3  (in_sum_3),
    .in_sum_4  (in_sum_4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res)
`ifdef PSR_OVF_CHECK_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s0, s1, s2, s3, s4;
    logic [W-1:0] exp;
    logic         exp_ovf;
    int           hold;
    bit           early;
  } vec_t;

  task automatic chk(input bit ok, input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r[W-1:0];
  endfunction

  function automatic logic [W:0] golden(input logic [W-1:0] a0, a1, a2, a3, a4);
    logic [W-1:0] a;
    logic [W:0]   t;
    logic         o;
    logic [W-1:0] s [5];
    s[0] = a0; s[1] = a1; s[2] = a2; s[3] = a3; s[4] = a4;
    a = '0;
    o = 1'b0;
    for (int i = 0; i < 5; i++) begin
      t = {1'b0, a} + {1'b0, s[i]};
      o = o | t[W];
      a = t[W-1:0];
    end
    return {o, a};
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk(in_ready == 1'b1, {tag, "_wait_in_ready"}, W'(in_ready), W'(1));
  endtask

  // One full transaction: accept, scribble on inputs during ACCUM, check latency,
  // hold under backpressure, then handshake.
  task automatic txn(input logic [W-1:0] s0, s1, s2, s3, s4, input logic [W-1:0] exp,
                     input logic exp_ovf, input int hold, input bit early, input string tag);
    int lat;
    wait_ready(tag);
    in_valid = 1'b1;
    in_sum_0 = s0; in_sum_1 = s1; in_sum_2 = s2; in_sum_3 = s3; in_sum_4 = s4;
    out_ready = early;
    step();
    chk(in_ready == 1'b0, {tag, "_in_ready_after_accept"}, W'(in_ready), W'(0));
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = 1'($urandom_range(0, 1));
      in_sum_0 = rnd_w(); in_sum_1 = rnd_w(); in_sum_2 = rnd_w();
      in_sum_3 = rnd_w(); in_sum_4 = rnd_w();
      step();
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk(lat == 5, {tag, "_latency"}, W'(lat), W'(5));
    chk(out_res == exp, {tag, "_out_res"}, out_res, exp);
`ifdef PSR_OVF_CHECK_EN
    chk(out_ovf == exp_ovf, {tag, "_out_ovf"}, W'(out_ovf), W'(exp_ovf));
`else
    if (exp_ovf === 1'bx) chk(1'b0, {tag, "_ovf_x"}, '0, '0);
`endif
    for (int h = 0; h < hold; h++) begin
      step();
      chk(out_valid == 1'b1 && out_res == exp, {tag, "_hold_res"}, out_res, exp);
      chk(in_ready == 1'b0, {tag, "_hold_in_ready"}, W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk(out_valid == 1'b0 && out_res == '0, {tag, "_after_hs_res"}, out_res, '0);
    chk(in_ready == 1'b1, {tag, "_after_hs_in_ready"}, W'(in_ready), W'(1));
  endtask

  vec_t         vecs [6];
  logic [W-1:0] ones;
  logic [W-1:0] top;
  logic [W:0]   g;
  logic [W-1:0] r0, r1, r2, r3, r4;
  int           seen;

  initial begin
    ones = '1;
    top  = '0;
    top[W-1] = 1'b1;
    vecs[0] = '{s0: W'(1), s1: W'(2), s2: W'(3), s3: W'(4), s4: W'(5),
                exp: W'(15), exp_ovf: 1'b0, hold: 0, early: 1'b1};
    vecs[1] = '{s0: W'(1), s1: W'(2), s2: W'(3), s3: W'(4), s4: W'(5),
                exp: W'(15), exp_ovf: 1'b0, hold: 10, early: 1'b0};
    vecs[2] = '{s0: ones, s1: W'(2), s2: '0, s3: '0, s4: '0,
                exp: W'(1), exp_ovf: 1'b1, hold: 1, early: 1'b0};
    vecs[3] = '{s0: '0, s1: '0, s2: '0, s3: '0, s4: '0,
                exp: '0, exp_ovf: 1'b0, hold: 0, early: 1'b0};
    vecs[4] = '{s0: ones, s1: ones, s2: ones, s3: ones, s4: ones,
                exp: ones - W'(4), exp_ovf: 1'b1, hold: 2, early: 1'b1};
    vecs[5] = '{s0: top, s1: top, s2: W'(100), s3: W'(200), s4: W'(300),
                exp: W'(600), exp_ovf: 1'b1, hold: 0, early: 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_sum_0 = '0; in_sum_1 = '0; in_sum_2 = '0; in_sum_3 = '0; in_sum_4 = '0;
    step();
    step();
    chk(in_ready == 1'b0, "reset_in_ready_low", W'(in_ready), W'(0));
    chk(out_valid == 1'b0, "reset_out_valid", W'(out_valid), W'(0));
    chk(out_res == '0, "reset_out_res", out_res, '0);
`ifdef PSR_OVF_CHECK_EN
    chk(out_ovf == 1'b0, "reset_out_ovf", W'(out_ovf), W'(0));
`endif
    rst = 1'b0;
    #1;
    chk(in_ready == 1'b1, "reset_release_in_ready", W'(in_ready), W'(1));

    for (int i = 0; i < 6; i++) begin
      txn(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].s4,
          vecs[i].exp, vecs[i].exp_ovf, vecs[i].hold, vecs[i].early,
          $sformatf("vec%0d", i));
    end

    // Reset two cycles into ACCUM must discard the operation.
    wait_ready("rstmid");
    in_valid = 1'b1;
    in_sum_0 = W'(7); in_sum_1 = W'(7); in_sum_2 = W'(7); in_sum_3 = W'(7); in_sum_4 = W'(7);
    step();
    in_valid = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk(in_ready == 1'b0, "rstmid_in_ready", W'(in_ready), W'(0));
    chk(out_valid == 1'b0, "rstmid_out_valid", W'(out_valid), W'(0));
    step();
    rst = 1'b0;
    #1;
    chk(in_ready == 1'b1, "rstmid_idle", W'(in_ready), W'(1));
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (out_valid) seen++;
    end
    chk(seen == 0, "rstmid_no_out_valid", W'(seen), W'(0));
    txn(W'(10), W'(20), W'(30), W'(40), W'(50), W'(150), 1'b0, 0, 1'b0, "rstmid_fresh");

    for (int n = 0; n < 1000; n++) begin
      r0 = rnd_w(); r1 = rnd_w(); r2 = rnd_w(); r3 = rnd_w(); r4 = rnd_w();
      if (n % 50 == 0) r0 = ones;
      g = golden(r0, r1, r2, r3, r4);
      txn(r0, r1, r2, r3, r4, g[W-1:0], g[W], $urandom_range(0, 3),
          1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/partial_sum_reducer.md
PARTIAL_SUM_REDUCER -- requirements
Module: partial_sum_reducer

Interface
REQ-001 SHALL have parameter RADIX, default 108, the limb radix; the datapath width W = 2*RADIX (216 bits at default).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1 bit, which marks the five partial sums as valid.
REQ-005 SHALL have port in_ready, output, 1 bit, which indicates the block can accept a new set.
REQ-006 SHALL have ports in_sum_0..in_sum_4, input, W bits each, the five partial sums from the partial-product adder stage.
REQ-007 SHALL have port out_valid, output, 1 bit, which marks the final product as valid.
REQ-008 SHALL have port out_ready, input, 1 bit, the downstream accept.
REQ-009 SHALL have port out_res, output, W bits, the final reduced product.
REQ-010 SHALL have port out_ovf, output, 1 bit, the sticky carry-out flag; this port exists only when PSR_OVF_CHECK_EN is defined.

Function
REQ-011 SHALL implement an FSM with states IDLE, ACCUM and DONE.
REQ-012 SHALL drive in_ready = 1 only in IDLE; SHALL drive in_ready = 0 in ACCUM and DONE.
REQ-013 SHALL accept an input on an edge where in_valid && in_ready; on acceptance it SHALL register in_sum_0..4, clear acc to 0, set idx to 0 and move to ACCUM.
REQ-014 In ACCUM, each edge SHALL perform acc <= (acc + sum[idx]) mod 2^W and idx <= idx + 1; the transition after idx = 4 SHALL be to DONE.
REQ-015 Latency: acceptance at edge t0 SHALL yield out_valid = 1 after edge t5 (exactly 5 accumulate edges).
REQ-016 In DONE, SHALL drive out_valid = 1 and out_res = acc, and SHALL hold both stable until the handshake.
REQ-017 On an edge in DONE where out_ready = 1, SHALL return to IDLE and deassert out_valid; the earliest next acceptance is the following edge (minimum period: 7 cycles per result).
REQ-018 SHALL ignore in_valid outside IDLE; input data SHALL NOT be sampled outside the accept edge.
REQ-019 SHALL ignore out_ready outside DONE.
REQ-020 Arithmetic SHALL be unsigned and truncated to W bits; sums SHALL wrap modulo 2^W.
REQ-021 SHALL drive out_res = 0 whenever out_valid = 0.

Reset
REQ-022 On rst = 1, regardless of clk: state = IDLE, acc = 0, idx = 0, captured sums = 0, out_valid = 0, out_res = 0, in_ready = 1 once rst is released, out_ovf = 0.
REQ-023 Reset asserted during ACCUM or DONE SHALL discard the operation in progress; no out_valid pulse SHALL follow.
REQ-024 While rst = 1, in_ready SHALL be 0.

Configuration
REQ-025 Macro PSR_OVF_CHECK_EN defined: each accumulate SHALL compute a W+1-bit sum; a carry-out SHALL set the sticky out_ovf flag; out_ovf SHALL be cleared on acceptance and SHALL be valid with out_valid.
REQ-026 Macro PSR_OVF_CHECK_EN undefined: the out_ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 Scenario 1 -- basic: sums 1, 2, 3, 4, 5 with out_ready = 1. Required: out_valid is high exactly 5 edges after accept, out_res = 15, and the FSM returns to IDLE.
REQ-028 Scenario 2 -- backpressure: out_ready = 0 for 10 cycles, then 1. Required: out_valid and out_res are held stable throughout, and in_ready stays 0 until the handshake edge.
REQ-029 Scenario 3 -- wrap: sum_0 = 2^W-1, sum_1 = 2, others 0. Required: out_res = 1, and out_ovf = 1 when the macro is defined.
REQ-030 Scenario 4 -- reset mid-op: rst asserted 2 cycles after accept. Required: out_valid never rises, acc = 0, the FSM is in IDLE, and a fresh set after release gives the correct result.
REQ-031 Scenario 5 -- ignored input: toggle in_valid with new data during ACCUM. Required: the result reflects only the originally accepted set.
REQ-032 Scenario 6 -- random: 1000 random sets with random out_ready. Required: each out_res equals the golden (s0+s1+s2+s3+s4) mod 2^W.
